// File: rtl/gfx_pkg.sv
// Shared graphics-pipeline types and default geometry for the Centipede tile path.
package gfx_pkg;
  localparam int GFX_PIX_W = 2;
  localparam int GFX_NPIX  = 8;

  typedef logic [GFX_PIX_W-1:0] gfx_pix_t;

  typedef struct packed {
    logic [GFX_NPIX*GFX_PIX_W-1:0] data;
    logic                          flip;
  } gfx_row_t;
endpackage

// File: rtl/tile_row_serializer_row_shifter.sv
// row_shifter: active-row register with stored flip, pixel counter and head-pixel select.
module row_shifter
  import gfx_pkg::*;
#(
  parameter int PIX_W = GFX_PIX_W,
  parameter int NPIX  = GFX_NPIX,
  localparam int IDX_W = $clog2(NPIX)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load_i,
  input  logic [NPIX*PIX_W-1:0] load_data_i,
  input  logic                  load_flip_i,
  input  logic                  adv_i,
  output logic                  valid_o,
  output logic                  last_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic [PIX_W-1:0]      pix_o
);
  logic [NPIX*PIX_W-1:0] data_q, data_d;
  logic                  flip_q, flip_d;
  logic                  valid_q, valid_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      pos;

  assign last_o  = (idx_q == IDX_W'(NPIX - 1));
  assign valid_o = valid_q;
  assign idx_o   = idx_q;
  // NPIX is a power of two, so NPIX-1-idx is simply the bitwise complement.
  assign pos     = flip_q ? ~idx_q : idx_q;
  assign pix_o   = valid_q ? data_q[pos*PIX_W +: PIX_W] : '0;

  // A load takes priority: it is how a finishing row hands over to the next one.
  always_comb begin
    data_d  = data_q;
    flip_d  = flip_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    if (load_i) begin
      data_d  = load_data_i;
      flip_d  = load_flip_i;
      valid_d = 1'b1;
      idx_d   = '0;
    end else if (adv_i) begin
      idx_d = idx_q + 1'b1;
      if (last_o) begin
        valid_d = 1'b0;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      data_q  <= '0;
      flip_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      data_q  <= data_d;
      flip_q  <= flip_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: rtl/tile_row_serializer.sv
// Parallel-in serial-out tile row serializer with a one-row holding buffer.
// Optional macro TILE_ROW_SERIALIZER_TRANSPARENCY_EN treats pixel index 0 as transparent.
module tile_row_serializer
  import gfx_pkg::*;
#(
  parameter int PIX_W = GFX_PIX_W,
  parameter int NPIX  = GFX_NPIX
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NPIX*PIX_W-1:0] row_data,
  input  logic                  row_flip,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  pix_en,
  output logic [PIX_W-1:0]      pix_out,
  output logic                  pix_valid,
  output logic                  pix_opaque,
  output logic                  row_start,
  output logic                  underrun,
  input  logic                  err_clr
);
  localparam int IDX_W = $clog2(NPIX);

  // Handshake: a row transfers on any edge where load_valid & load_ready;
  // load_ready depends only on registered hold state.
  logic [NPIX*PIX_W-1:0] hold_data_q, hold_data_d;
  logic                  hold_flip_q, hold_flip_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  underrun_q, underrun_d;

  logic                  sh_valid, sh_last, sh_load, sh_flip;
  logic [IDX_W-1:0]      sh_idx;
  logic [NPIX*PIX_W-1:0] sh_data;
  logic                  accept, consume, row_end, from_hold;

  assign load_ready = ~hold_valid_q;
  assign accept     = load_valid & load_ready;
  assign consume    = pix_en & sh_valid;
  assign row_end    = consume & sh_last;
  assign from_hold  = row_end & hold_valid_q;
  assign sh_load    = from_hold | (accept & (~sh_valid | (row_end & ~hold_valid_q)));
  assign sh_data    = from_hold ? hold_data_q : row_data;
  assign sh_flip    = from_hold ? hold_flip_q : row_flip;

  row_shifter #(.PIX_W(PIX_W), .NPIX(NPIX)) u_shifter (
    .clk         (clk),
    .clr         (clr),
    .load_i      (sh_load),
    .load_data_i (sh_data),
    .load_flip_i (sh_flip),
    .adv_i       (consume),
    .valid_o     (sh_valid),
    .last_o      (sh_last),
    .idx_o       (sh_idx),
    .pix_o       (pix_out)
  );

  always_comb begin
    hold_data_d  = hold_data_q;
    hold_flip_d  = hold_flip_q;
    hold_valid_d = hold_valid_q;
    if (from_hold) begin
      hold_valid_d = 1'b0;
    end else if (accept && sh_valid && !row_end) begin
      hold_data_d  = row_data;
      hold_flip_d  = row_flip;
      hold_valid_d = 1'b1;
    end
    underrun_d = underrun_q;
    if (pix_en && !sh_valid) underrun_d = 1'b1;
    else if (err_clr)        underrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hold_data_q  <= '0;
      hold_flip_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      hold_data_q  <= hold_data_d;
      hold_flip_q  <= hold_flip_d;
      hold_valid_q <= hold_valid_d;
      underrun_q   <= underrun_d;
    end
  end

  assign pix_valid = sh_valid;
  assign row_start = sh_valid & (sh_idx == '0);
  assign underrun  = underrun_q;

`ifdef TILE_ROW_SERIALIZER_TRANSPARENCY_EN
  assign pix_opaque = sh_valid & (pix_out != '0);
`else
  assign pix_opaque = sh_valid;
`endif
endmodule

// File: tb/tb_tile_row_serializer.sv
// Directed bench for tile_row_serializer: inputs change and outputs are sampled on the falling edge.
module tb_tile_row_serializer;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] row_data = '0;
  logic        row_flip = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic        pix_en = 1'b0;
  logic [1:0]  pix_out;
  logic        pix_valid, pix_opaque, row_start, underrun;
  logic        err_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  tile_row_serializer #(.PIX_W(2), .NPIX(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .row_data   (row_data),
    .row_flip   (row_flip),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .pix_en     (pix_en),
    .pix_out    (pix_out),
    .pix_valid  (pix_valid),
    .pix_opaque (pix_opaque),
    .row_start  (row_start),
    .underrun   (underrun),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", pix_valid); end
    n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", load_ready); end
    n_checks++; if (pix_out !== 2'd0) begin n_fail++; $display("FAIL rst_pix got %0d exp 0", pix_out); end
    n_checks++; if ({pix_opaque, row_start, underrun} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b exp 000", {pix_opaque, row_start, underrun}); end
    #2 clr = 1'b1;
    #1;
    n_checks++; if ({pix_valid, load_ready, pix_out} !== 4'b0100) begin n_fail++; $display("FAIL rst_release got %b exp 0100", {pix_valid, load_ready, pix_out}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({pix_valid, load_ready, pix_out, underrun} !== 5'b01000) begin n_fail++; $display("FAIL idle_%0d got %b exp 01000", i, {pix_valid, load_ready, pix_out, underrun}); end
    end
  endtask

  // Loads one row, then streams all 8 pixels; flip is toggled after acceptance.
  task automatic test_row(input logic flip, input logic [1:0] exp_px [8]);
    row_data = 16'hE4E4; row_flip = flip; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    pix_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL row_f%0d_valid%0d got %b exp 1", flip, i, pix_valid); end
      n_checks++; if (pix_out !== exp_px[i]) begin n_fail++; $display("FAIL row_f%0d_pix%0d got %0d exp %0d", flip, i, pix_out, exp_px[i]); end
      n_checks++; if (row_start !== (i == 0)) begin n_fail++; $display("FAIL row_f%0d_start%0d got %b exp %b", flip, i, row_start, (i == 0)); end
      row_flip = ~row_flip;
      @(negedge clk);
    end
    pix_en = 1'b0;
    n_checks++; if ({pix_valid, pix_out, load_ready} !== 4'b0001) begin n_fail++; $display("FAIL row_f%0d_end got %b exp 0001", flip, {pix_valid, pix_out, load_ready}); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL row_f%0d_underrun got %b exp 0", flip, underrun); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rows [3];
    logic [1:0]  px [3];
    int sent = 0, count = 0;
    logic ready_seen = 1'b0, saw_low = 1'b0, done = 1'b0;
    rows = '{16'h0000, 16'hFFFF, 16'h5555};
    px   = '{2'd0, 2'd3, 2'd1};
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (load_valid && ready_seen) sent++;
      if (sent < 3) begin row_data = rows[sent]; row_flip = 1'b0; load_valid = 1'b1; end
      else load_valid = 1'b0;
      ready_seen = load_ready;
      if (load_valid && !load_ready) saw_low = 1'b1;
      if (count == 24) begin
        pix_en = 1'b0;
        done = 1'b1;
      end else if (pix_valid) begin
        pix_en = 1'b1;
        n_checks++; if (pix_out !== px[count/8]) begin n_fail++; $display("FAIL b2b_pix%0d got %0d exp %0d", count, pix_out, px[count/8]); end
        n_checks++; if (row_start !== (count % 8 == 0)) begin n_fail++; $display("FAIL b2b_start%0d got %b exp %b", count, row_start, (count % 8 == 0)); end
        count++;
      end else if (count > 0) begin
        n_checks++; n_fail++; $display("FAIL b2b_gap after pixel %0d got valid 0 exp 1", count);
      end
      if (!done) @(negedge clk);
    end
    load_valid = 1'b0; pix_en = 1'b0;
    n_checks++; if (count !== 24) begin n_fail++; $display("FAIL b2b_count got %0d exp 24", count); end
    n_checks++; if (saw_low !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_low got %b exp 1", saw_low); end
    n_checks++; if ({pix_valid, load_ready, underrun} !== 3'b010) begin n_fail++; $display("FAIL b2b_end got %b exp 010", {pix_valid, load_ready, underrun}); end
  endtask

  task automatic test_underrun();
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_init got %b exp 0", underrun); end
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_set got %b exp 1", underrun); end
    repeat (3) @(negedge clk);
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_sticky got %b exp 1", underrun); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_clear got %b exp 0", underrun); end
    err_clr = 1'b1; pix_en = 1'b1;
    @(negedge clk);
    err_clr = 1'b0; pix_en = 1'b0;
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_set_wins got %b exp 1", underrun); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_clear2 got %b exp 0", underrun); end
  endtask

  task automatic test_opaque_and_clr();
    logic [1:0] px [8];
    logic       opq [8];
    px = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
`ifdef TILE_ROW_SERIALIZER_TRANSPARENCY_EN
    opq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    opq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    row_data = 16'h00E4; row_flip = 1'b0; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; pix_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if ({pix_out, pix_opaque} !== {px[i], opq[i]}) begin n_fail++; $display("FAIL opq_%0d got pix %0d opq %b exp pix %0d opq %b", i, pix_out, pix_opaque, px[i], opq[i]); end
      @(negedge clk);
    end
    pix_en = 1'b0;
    row_data = 16'h00E4; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; pix_en = 1'b1;
    repeat (3) @(negedge clk);
    pix_en = 1'b0;
    n_checks++; if ({pix_valid, pix_out, pix_opaque} !== 4'b1111) begin n_fail++; $display("FAIL clr_pre got %b exp 1111", {pix_valid, pix_out, pix_opaque}); end
    #2 clr = 1'b0;
    #1;
    n_checks++; if ({pix_valid, pix_out, pix_opaque, row_start, load_ready} !== 6'b000001) begin n_fail++; $display("FAIL clr_async got %b exp 000001", {pix_valid, pix_out, pix_opaque, row_start, load_ready}); end
    #4 clr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++; if ({pix_valid, pix_out} !== 3'b000) begin n_fail++; $display("FAIL clr_after_%0d got %b exp 000", i, {pix_valid, pix_out}); end
    end
  endtask

  initial begin
    logic [1:0] fwd [8];
    logic [1:0] rev [8];
    fwd = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    rev = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    test_reset();
    test_row(1'b0, fwd);
    test_row(1'b1, rev);
    test_back_to_back();
    test_underrun();
    test_opaque_and_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tile_row_serializer.md
# tile_row_serializer

Parallel-in, serial-out pixel serializer for the Centipede graphics pipeline. It is the transmit-side counterpart of the library's serial-in shift register. It accepts one tile row (NPIX packed pixel indices) from the tile/sprite fetch logic over a valid/ready handshake, then emits one pixel per pixel-enable strobe toward the palette/VGA stage. A one-row holding buffer allows back-to-back rows with no bubble.

## Interface
- PIX_W, 2: bits per pixel (palette index width).
- NPIX, 8: pixels per tile row; power of two, at least 2.
- clk  in  1  system clock; all state on posedge.
- clr  in  1  asynchronous, active-low reset.
- row_data  in  NPIX*PIX_W  packed row; pixel i = row_data[i*PIX_W +: PIX_W].
- row_flip  in  1  horizontal mirror for this row; sampled with row_data.
- load_valid  in  1  row_data/row_flip valid.
- load_ready  out  1  block can accept a row this cycle.
- pix_en  in  1  pixel strobe; consumes the current pixel.
- pix_out  out  PIX_W  current pixel index.
- pix_valid  out  1  pix_out holds a real pixel.
- pix_opaque  out  1  see Configuration.
- row_start  out  1  pix_out is pixel 0 of a row.
- underrun  out  1  sticky: pix_en seen while pix_valid=0.
- err_clr  in  1  synchronous clear of underrun.

## Operation
- Two entries: the shifter (active row plus pixel counter `idx`, $clog2(NPIX) bits) and hold (next row). Each entry has a valid flag and a stored flip bit.
- load_ready = ~hold_valid. It is a function of registered state only; there is no combinational path from pix_en or load_valid.
- Accept occurs when load_valid & load_ready at the clock edge. The accepted row goes:
  - into the shifter if the shifter is empty, or if the shifter's last pixel is consumed in the same cycle while hold is empty;
  - otherwise into hold.
- Output order:
  - row_flip=0: pixel 0 first, ascending.
  - row_flip=1: pixel NPIX-1 first, descending.
  - The flip bit is stored with the row, so row_flip changes after acceptance have no effect.
- pix_valid = shifter_valid. pix_out is the head pixel when valid and 0 otherwise. row_start = pix_valid & (idx==0).
- Consume occurs on pix_en & pix_valid: idx increments.
  - When idx==NPIX-1, the row ends and idx wraps to 0.
  - The shifter then reloads from hold (hold_valid clears), or from a same-cycle accepted load if hold is empty. If neither is available, shifter_valid clears.
- pix_en & ~pix_valid sets underrun. Only err_clr or clr clears it; when both err_clr and a new underrun occur in the same cycle, set wins.
- With both entries full and no pix_en, state holds indefinitely and load_ready stays 0.
- Async reset (clr=0) discards both entries immediately. On deassertion, the block starts empty.

## Timing
- Reset values: load_ready=1, pix_valid=0, pix_out=0, pix_opaque=0, row_start=0, underrun=0, idx=0.
- A row accepted at edge k into an empty shifter gives pix_valid=1 and row_start=1 after edge k (latency 1).
- A continuous pix_en with a row always pending yields exactly one pixel per cycle. Across a row boundary there are no gaps.
- A row occupies the shifter for NPIX consuming cycles. load_ready rises the cycle after hold is drained.

## Configuration
- Macro: TILE_ROW_SERIALIZER_TRANSPARENCY_EN.
- Defined: pix_opaque = pix_valid & (pix_out != 0). Index 0 is the transparent pixel, used by the sprite/background mixer.
- Undefined: pix_opaque = pix_valid. All indices are opaque and no zero-compare logic is built.

## Structure
- Shared package gfx_pkg holds:
  - localparams GFX_PIX_W=2 and GFX_NPIX=8;
  - typedef gfx_pix_t (logic [GFX_PIX_W-1:0]);
  - typedef gfx_row_t (packed row plus flip bit).
- One sub-module, row_shifter: parallel-load register with stored flip, idx counter and head-pixel select. The top level holds hold, the handshake and underrun.

## Test plan
All scenarios use PIX_W=2, NPIX=8.
- Reset then idle: pix_valid=0, load_ready=1, pix_out=0 throughout. Release clr mid-cycle and check that outputs are still at their reset values.
- Load 16'hE4E4 with flip=0, then pix_en high for 8 cycles: pix_out=0,1,2,3,0,1,2,3; row_start only on the first; then pix_valid=0.
- Same row with flip=1: pix_out=3,2,1,0,3,2,1,0. Toggling row_flip after acceptance changes nothing.
- Three rows offered back-to-back (16'h0000, 16'hFFFF, 16'h5555) with pix_en held high: 24 consecutive valid pixels (8×0, 8×3, 8×1) with no gap. load_ready drops to 0 while hold is full.
- pix_en with the block empty: underrun=1 and it stays set. err_clr pulse returns it to 0. err_clr plus a new underrun in the same cycle leaves it at 1.
- Load row 16'h00E4 (pixels 0,1,2,3,0,0,0,0): with the macro, pix_opaque=0,1,1,1,0,0,0,0; without it, all 1. Assert clr after 3 pixels: pix_valid=0 immediately and the remaining pixels are never emitted.
